// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Holds the geometry constants, the BTB entry layout, the counter
// reset/allocate values and the PC -> index/tag split.
package bp_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ENTRIES    = 64;
  localparam int unsigned CTR_BITS   = 2;
  localparam int unsigned PERF_W_DEF = 32;

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  // Weak taken is the MSB alone; weak not-taken sits just below it.
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

  typedef struct packed {
    logic                valid;
    logic                jump;
    logic [TAG_W-1:0]    tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } bp_entry_t;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  function automatic logic [IDX_W-1:0] idx_of(input logic [XLEN-1:0] pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> predictor connection.
// master: pipeline datapath (drives PCF and the resolved-branch fields from E).
// slave : predictor (returns the F prediction, E mispredict/redirect, perf counters).
interface branch_predictor_if #(
  parameter int unsigned PERF_W = bp_pkg::PERF_W_DEF
);
  logic [bp_pkg::XLEN-1:0] PCF;
  logic                    PredTakenF;
  logic [bp_pkg::XLEN-1:0] PredTargetF;
  logic                    UpdateE;
  logic                    IsJumpE;
  logic [bp_pkg::XLEN-1:0] PCE;
  logic                    TakenE;
  logic [bp_pkg::XLEN-1:0] TargetE;
  logic                    PredTakenE;
  logic [bp_pkg::XLEN-1:0] PredTargetE;
  logic                    MispredictE;
  logic [bp_pkg::XLEN-1:0] RedirectPCE;
  logic [PERF_W-1:0]       BranchCount;
  logic [PERF_W-1:0]       MissCount;

  modport master (
    output PCF, UpdateE, IsJumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MissCount
  );

  modport slave (
    input  PCF, UpdateE, IsJumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MissCount
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter step (combinational).
// ctr   : current value
// inc   : 1 = count up, 0 = count down
// en    : 0 = pass ctr through unchanged
// ctr_c : next value, clamped to [0, 2^W-1]
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  input  logic         en,
  output logic [W-1:0] ctr_c
);
  always_comb begin
    ctr_c = ctr;
    if (en) begin
      if (inc) begin
        if (ctr != '1) ctr_c = ctr + W'(1);
      end else begin
        if (ctr != '0) ctr_c = ctr - W'(1);
      end
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters.
// clk, reset : rising-edge clock, asynchronous active-high reset
// bus        : slave side of branch_predictor_if -- same-cycle prediction for
//              PCF, E-stage mispredict/redirect, training from E, perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input logic             clk,
  input logic             reset,
  branch_predictor_if.slave bus
);
  localparam bp_entry_t ENTRY_RESET = '{
    valid: 1'b0, jump: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT
  };

  bp_entry_t           entries_q [ENTRIES];
  logic [PERF_W-1:0]   branch_cnt_q;
  logic [PERF_W-1:0]   miss_cnt_q;
  logic [IDX_W-1:0]    look_idx;
  logic [IDX_W-1:0]    upd_idx;
  logic                look_hit;
  logic                upd_hit;
  logic                pred_taken;
  logic                mispredict;
  logic [CTR_BITS-1:0] ctr_next;

  // Fetch lookup: reads the registered array, so an update to the same
  // index in this cycle is not yet visible.
  assign look_idx   = idx_of(bus.PCF);
  assign look_hit   = entries_q[look_idx].valid && (entries_q[look_idx].tag == tag_of(bus.PCF));
  assign pred_taken = look_hit && (entries_q[look_idx].jump || entries_q[look_idx].ctr[CTR_BITS-1]);

  assign bus.PredTakenF  = pred_taken;
  assign bus.PredTargetF = pred_taken ? entries_q[look_idx].target : bus.PCF + XLEN'(4);

  // Execute-stage resolution.
  assign mispredict = bus.UpdateE &&
                      ((bus.PredTakenE != bus.TakenE) ||
                       (bus.TakenE && (bus.PredTargetE != bus.TargetE)));

  assign bus.MispredictE = mispredict;
  assign bus.RedirectPCE = bus.TakenE ? bus.TargetE : bus.PCE + XLEN'(4);
  assign bus.BranchCount = branch_cnt_q;
  assign bus.MissCount   = miss_cnt_q;

  assign upd_idx = idx_of(bus.PCE);
  assign upd_hit = entries_q[upd_idx].valid && (entries_q[upd_idx].tag == tag_of(bus.PCE));

  sat_counter #(.W(CTR_BITS)) u_ctr (
    .ctr   (entries_q[upd_idx].ctr),
    .inc   (bus.TakenE),
    .en    (bus.UpdateE),
    .ctr_c (ctr_next)
  );

  // Training: hits adjust counter/target/kind; taken misses allocate weak-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= ENTRY_RESET;
    end else if (bus.UpdateE) begin
      if (upd_hit) begin
        entries_q[upd_idx].ctr  <= ctr_next;
        entries_q[upd_idx].jump <= bus.IsJumpE;
        if (bus.TakenE) entries_q[upd_idx].target <= bus.TargetE;
      end else if (bus.TakenE) begin
        entries_q[upd_idx] <= '{
          valid:  1'b1,
          jump:   bus.IsJumpE,
          tag:    tag_of(bus.PCE),
          target: bus.TargetE,
          ctr:    CTR_WEAK_T
        };
      end
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (bus.UpdateE && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + PERF_W'(1);
      if (mispredict && (miss_cnt_q != '1))    miss_cnt_q   <= miss_cnt_q + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, compared against a table model kept in plain integers.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int unsigned PW    = 6;
  localparam int          CMAX  = (1 << CTR_BITS) - 1;
  localparam int          CHALF = 1 << (CTR_BITS - 1);
  localparam int          PMAX  = (1 << PW) - 1;
  localparam longint unsigned AMOD = longint'(1) << XLEN;

  logic clk = 1'b0;
  logic reset;

  branch_predictor_if #(.PERF_W(PW)) bus ();

  branch_predictor #(.PERF_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-slot contents, counter kept as an int in [0, CMAX].
  bit              m_valid [ENTRIES];
  bit              m_jump  [ENTRIES];
  longint unsigned m_tag   [ENTRIES];
  longint unsigned m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  int              m_bc;
  int              m_mc;

  // Last DUT values seen by step(), for scenario-specific constant checks.
  logic            last_pt;
  logic [63:0]     last_ptgt;
  logic            last_mis;
  logic [63:0]     last_redir;

  longint unsigned pc_pool  [8] = '{64'h100, 64'h104, 64'h200, 64'h300,
                                    64'h400, 64'h1100, 64'h108, 64'h500};
  longint unsigned tgt_pool [4] = '{64'h40, 64'h80, 64'hC0, 64'h1000};

  function automatic int m_idx(input longint unsigned pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint unsigned m_tagof(input longint unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_jump[i]  = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = CHALF - 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic m_predict(input longint unsigned pc, output bit tk, output longint unsigned tgt);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_jump[i] || (m_ctr[i] >= CHALF));
    tgt = tk ? m_tgt[i] : (pc + 4) % AMOD;
  endtask

  task automatic m_train(input longint unsigned pc, input bit tk, input longint unsigned tgt, input bit jmp);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && (m_tag[i] == m_tagof(pc))) begin
      if (tk) m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
      else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if (tk) m_tgt[i] = tgt;
      m_jump[i] = jmp;
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(pc);
      m_tgt[i]   = tgt;
      m_jump[i]  = jmp;
      m_ctr[i]   = CHALF;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input longint unsigned exp);
    n_tests++;
    assert (obs === 64'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational outputs before the edge,
  // then advance the model across the edge.
  task automatic step(input string tag, input longint unsigned pcf, input bit upd, input bit jmp,
                      input longint unsigned pce, input bit tk, input longint unsigned tgt,
                      input bit ptk, input longint unsigned ptgt);
    bit              etk;
    longint unsigned etgt;
    bit              emis;
    longint unsigned eredir;
    bus.PCF         = XLEN'(pcf);
    bus.UpdateE     = upd;
    bus.IsJumpE     = jmp;
    bus.PCE         = XLEN'(pce);
    bus.TakenE      = tk;
    bus.TargetE     = XLEN'(tgt);
    bus.PredTakenE  = ptk;
    bus.PredTargetE = XLEN'(ptgt);
    #2;
    m_predict(pcf, etk, etgt);
    emis   = upd && ((ptk != tk) || (tk && (ptgt != tgt)));
    eredir = tk ? tgt : (pce + 4) % AMOD;
    last_pt    = bus.PredTakenF;
    last_ptgt  = 64'(bus.PredTargetF);
    last_mis   = bus.MispredictE;
    last_redir = 64'(bus.RedirectPCE);
    check({tag, ".pred_taken"},  64'(bus.PredTakenF),  64'(etk));
    check({tag, ".pred_target"}, 64'(bus.PredTargetF), etgt);
    check({tag, ".mispredict"},  64'(bus.MispredictE), 64'(emis));
    check({tag, ".redirect"},    64'(bus.RedirectPCE), eredir);
    check({tag, ".branch_cnt"},  64'(bus.BranchCount), longint'(m_bc));
    check({tag, ".miss_cnt"},    64'(bus.MissCount),   longint'(m_mc));
    @(posedge clk);
    if (upd) begin
      if (m_bc < PMAX) m_bc++;
      if (emis && (m_mc < PMAX)) m_mc++;
      m_train(pce, tk, tgt, jmp);
    end
    #1;
  endtask

  task automatic idle(input string tag, input longint unsigned pcf);
    step(tag, pcf, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  // Resolve a branch at pc with the pipeline carrying the model's own prediction.
  task automatic resolve(input string tag, input longint unsigned pc, input bit tk,
                         input longint unsigned tgt, input bit jmp);
    bit              ptk;
    longint unsigned ptgt;
    m_predict(pc, ptk, ptgt);
    step(tag, pc, 1'b1, jmp, pc, tk, tgt, ptk, ptgt);
  endtask

  task automatic do_reset();
    bus.UpdateE = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    bit              mis_pat [5];
    bit              exp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit              loop_tk [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int              mc0;
    bit              ptk;
    longint unsigned ptgt;
    longint unsigned pce;
    longint unsigned tgt;
    bit              tk;

    reset = 1'b1;
    bus.PCF = XLEN'(32'h100);
    bus.UpdateE = 1'b0;
    bus.IsJumpE = 1'b0;
    bus.PCE = '0;
    bus.TakenE = 1'b0;
    bus.TargetE = '0;
    bus.PredTakenE = 1'b0;
    bus.PredTargetE = '0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state
    idle("t1", 64'h100);
    check("t1.pt_const",  64'(last_pt), 64'h0);
    check("t1.tgt_const", last_ptgt,    64'h104);

    // 2: first taken resolution allocates and mispredicts
    step("t2", 64'h100, 1'b1, 1'b0, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
    check("t2.mis_const",   64'(last_mis), 64'h1);
    check("t2.redir_const", last_redir,    64'h80);
    idle("t2b", 64'h100);
    check("t2b.pt_const",  64'(last_pt), 64'h1);
    check("t2b.tgt_const", last_ptgt,    64'h80);

    // 3: loop branch T,T,T,N,T
    mc0 = m_mc;
    for (int k = 0; k < 5; k++) begin
      resolve($sformatf("t3.%0d", k), 64'h200, loop_tk[k], 64'h240, 1'b0);
      mis_pat[k] = last_mis;
    end
    for (int k = 0; k < 5; k++) check($sformatf("t3.mis_pat%0d", k), 64'(mis_pat[k]), 64'(exp_pat[k]));
    idle("t3e", 64'h200);
    check("t3.miss_delta", 64'(bus.MissCount), longint'(mc0 + 2));

    // 4: jump entry stays taken with counter driven to 0; alias evicts it
    resolve("t4.alloc", 64'h300, 1'b1, 64'h50, 1'b1);
    for (int k = 0; k < 4; k++) resolve($sformatf("t4.nt%0d", k), 64'h300, 1'b0, 64'h50, 1'b1);
    idle("t4.q", 64'h300);
    check("t4.jump_taken", 64'(last_pt), 64'h1);
    check("t4.jump_tgt",   last_ptgt,    64'h50);
    resolve("t4.alias", 64'h300 + 4 * ENTRIES, 1'b1, 64'h60, 1'b0);
    idle("t4.evict", 64'h300);
    check("t4.evicted_pt",  64'(last_pt), 64'h0);
    check("t4.evicted_tgt", last_ptgt,    64'h304);

    // 5: same-cycle lookup/update reads pre-update contents
    do_reset();
    step("t5", 64'h400, 1'b1, 1'b0, 64'h400, 1'b1, 64'h88, 1'b0, 64'h404);
    check("t5.same_cycle_pt", 64'(last_pt), 64'h0);
    idle("t5b", 64'h400);
    check("t5.next_pt",  64'(last_pt), 64'h1);
    check("t5.next_tgt", last_ptgt,    64'h88);

    // Randomized traffic over a small, heavily aliasing PC set
    for (int n = 0; n < 400; n++) begin
      pce = pc_pool[$urandom_range(0, 7)];
      tgt = tgt_pool[$urandom_range(0, 3)];
      tk  = 1'($urandom_range(0, 1));
      m_predict(pce, ptk, ptgt);
      if ($urandom_range(0, 9) < 2) begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = tgt_pool[$urandom_range(0, 3)];
      end
      step($sformatf("rnd%0d", n), pc_pool[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), pce, tk, tgt, ptk, ptgt);
    end

    // 6: reset asserted mid-cycle with an allocating update in flight
    bus.PCF = XLEN'(32'h500);
    bus.UpdateE = 1'b1;
    bus.IsJumpE = 1'b0;
    bus.PCE = XLEN'(32'h500);
    bus.TakenE = 1'b1;
    bus.TargetE = XLEN'(32'h90);
    bus.PredTakenE = 1'b0;
    bus.PredTargetE = XLEN'(32'h504);
    #2;
    reset = 1'b1;
    #1;
    check("t6.rst_pt",  64'(bus.PredTakenF),  64'h0);
    check("t6.rst_tgt", 64'(bus.PredTargetF), 64'h504);
    check("t6.rst_bc",  64'(bus.BranchCount), 64'h0);
    check("t6.rst_mc",  64'(bus.MissCount),   64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.UpdateE = 1'b0;
    m_reset();
    idle("t6.after", 64'h500);
    check("t6.no_write_pt", 64'(last_pt), 64'h0);

    // 6b: force a mispredict every update until both counters saturate
    for (int k = 0; k < PMAX + 7; k++) begin
      pce = pc_pool[k % 8];
      m_predict(pce, ptk, ptgt);
      step($sformatf("sat%0d", k), pce, 1'b1, 1'b0, pce, ~ptk, 64'hC0, ptk, ptgt);
    end
    idle("t6.sat", 64'h100);
    check("t6.bc_max", 64'(bus.BranchCount), longint'(PMAX));
    check("t6.mc_max", 64'(bus.MissCount),   longint'(PMAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
